// File: rtl/cache_memory_assoc_pkg.sv
// Shared types and width helpers for the set-associative cache array.
package cache_memory_assoc_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef enum logic {
    StIdle,
    StInval
  } cache_state_e;

  // Index width that stays at least one bit wide for single-entry dimensions.
  function automatic int unsigned way_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_memory_assoc_lru_ctrl.sv
// True-LRU age tracking per set: ages form a permutation of 0..NUM_WAYS-1, 0 = MRU.
module cache_memory_assoc_lru_ctrl
  import cache_memory_assoc_pkg::*;
#(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned NUM_WAYS = 2,
  localparam int unsigned SET_WIDTH = way_width(NUM_SETS),
  localparam int unsigned WAY_WIDTH = way_width(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_WIDTH-1:0] upd_set_i,
  input  logic                 access_en_i,
  input  logic [WAY_WIDTH-1:0] access_way_i,
  input  logic                 restore_en_i,
  input  logic [NUM_WAYS-1:0]  valid_i,
  output logic [WAY_WIDTH-1:0] victim_o
);

  logic [WAY_WIDTH-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [WAY_WIDTH-1:0] age_d [NUM_WAYS];
  logic [WAY_WIDTH-1:0] acc_age;
  logic                 found;

  // Next ages of the addressed set: restore identity order, or promote the accessed way.
  always_comb begin
    acc_age = age_q[upd_set_i][access_way_i];
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      age_d[w] = age_q[upd_set_i][w];
      if (restore_en_i) begin
        age_d[w] = WAY_WIDTH'(w);
      end else if (WAY_WIDTH'(w) == access_way_i) begin
        age_d[w] = '0;
      end else if (age_q[upd_set_i][w] < acc_age) begin
        age_d[w] = age_q[upd_set_i][w] + WAY_WIDTH'(1);
      end
    end
  end

  // Age array; reset leaves way w with age w.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_WIDTH'(w);
        end
      end
    end else if (restore_en_i || access_en_i) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        age_q[upd_set_i][w] <= age_d[w];
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_WIDTH'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (age_q[upd_set_i][w] == WAY_WIDTH'(NUM_WAYS - 1)) victim_o = WAY_WIDTH'(w);
      end
    end
  end

endmodule

// File: rtl/cache_memory_assoc.sv
// N-way set-associative tag/data/state array with true-LRU replacement, refill and
// multi-cycle invalidate-all. Optional saturating hit/miss counters under CACHE_PERF_CNT_EN.
module cache_memory_assoc
  import cache_memory_assoc_pkg::*;
#(
  parameter int unsigned NUM_SETS        = 64,
  parameter int unsigned NUM_WAYS        = 2,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  localparam int unsigned INDEX_WIDTH  = $clog2(NUM_SETS),
  localparam int unsigned OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2,
  localparam int unsigned BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE,
  localparam int unsigned WAY_WIDTH    = way_width(NUM_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_type_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  input  logic [INDEX_WIDTH-1:0]  index_i,
  input  logic [OFFSET_WIDTH-1:0] blk_offset_i,
  input  logic [WORD_SIZE-1:0]    data_in_i,
  input  logic                    refill_valid_i,
  input  logic [BLOCK_SIZE-1:0]   data_in_mem_i,
  input  logic                    inval_all_i,
  output logic                    resp_valid_o,
  output logic                    hit_o,
  output logic [WORD_SIZE-1:0]    data_out_o,
  output logic                    dirty_bit_o,
  output logic [TAG_WIDTH-1:0]    victim_tag_o,
  output logic [BLOCK_SIZE-1:0]   dirty_block_out_o,
  output logic                    done_cache_o
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } line_state_t;

  cache_state_e state_q, state_d;
  logic [INDEX_WIDTH-1:0] set_cnt_q, set_cnt_d;

  line_state_t         line_q [NUM_WAYS][NUM_SETS];
  logic [BLOCK_SIZE-1:0] data_q [NUM_WAYS][NUM_SETS];
  logic [WAY_WIDTH-1:0] victim_way_q;

  logic                  resp_valid_q, hit_q, dirty_bit_q, done_q;
  logic [WORD_SIZE-1:0]  data_out_q;
  logic [TAG_WIDTH-1:0]  victim_tag_q;
  logic [BLOCK_SIZE-1:0] dirty_blk_q;

  logic inval_start, inval_step, inval_last, refill_en, accept, is_write, miss_dirty;
  logic                 hit_any;
  logic [WAY_WIDTH-1:0] hit_way, victim_way, lru_way;
  logic [NUM_WAYS-1:0]  set_valid;
  line_state_t          victim_line;
  logic [WORDS_PER_BLOCK-1:0][WORD_SIZE-1:0] hit_words, wr_words;

  // Request arbitration: invalidate-all beats refill, refill beats lookup.
  always_comb begin
    inval_start = (state_q == StIdle) && inval_all_i;
    inval_step  = (state_q == StInval);
    inval_last  = inval_step && (set_cnt_q == INDEX_WIDTH'(NUM_SETS - 1));
    refill_en   = (state_q == StIdle) && !inval_all_i && refill_valid_i;
    req_ready_o = (state_q == StIdle) && !refill_valid_i;
    accept      = req_valid_i && req_ready_o && !inval_all_i;
    is_write    = (req_type_i == REQ_WRITE);
  end

  // Tag match across the ways of the addressed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = line_q[w][index_i].valid;
      if (line_q[w][index_i].valid && (line_q[w][index_i].tag == tag_i)) begin
        hit_any = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
    end
    hit_words            = data_q[hit_way][index_i];
    wr_words             = hit_words;
    wr_words[blk_offset_i] = data_in_i;
    victim_way           = lru_way;
    victim_line          = line_q[victim_way][index_i];
    miss_dirty           = accept && !hit_any && victim_line.valid && victim_line.dirty;
  end

  cache_memory_assoc_lru_ctrl #(
    .NUM_SETS(NUM_SETS),
    .NUM_WAYS(NUM_WAYS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .upd_set_i   (inval_step ? set_cnt_q : index_i),
    .access_en_i (refill_en || (accept && hit_any)),
    .access_way_i(refill_en ? victim_way_q : hit_way),
    .restore_en_i(inval_step),
    .valid_i     (set_valid),
    .victim_o    (lru_way)
  );

  // FSM next state: walk every set once during invalidate-all.
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    case (state_q)
      StIdle: begin
        if (inval_start) begin
          state_d   = StInval;
          set_cnt_d = '0;
        end
      end
      StInval: begin
        set_cnt_d = set_cnt_q + INDEX_WIDTH'(1);
        if (inval_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  // Line state array: invalidate, refill into the latched victim, or mark a write hit dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        for (int unsigned s = 0; s < NUM_SETS; s++) line_q[w][s] <= '0;
      end
    end else if (inval_step) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) line_q[w][set_cnt_q] <= '0;
    end else if (refill_en) begin
      line_q[victim_way_q][index_i] <= '{valid: 1'b1, dirty: 1'b0, tag: tag_i};
    end else if (accept && hit_any && is_write) begin
      line_q[hit_way][index_i].dirty <= 1'b1;
    end
  end

  // Data array; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (refill_en) begin
      data_q[victim_way_q][index_i] <= data_in_mem_i;
    end else if (accept && hit_any && is_write) begin
      data_q[hit_way][index_i] <= wr_words;
    end
  end

  // Registered lookup response, victim latch and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      data_out_q   <= '0;
      dirty_bit_q  <= 1'b0;
      victim_tag_q <= '0;
      dirty_blk_q  <= '0;
      done_q       <= 1'b0;
      victim_way_q <= '0;
    end else begin
      resp_valid_q <= accept;
      hit_q        <= accept && hit_any;
      data_out_q   <= (accept && hit_any && !is_write) ? hit_words[blk_offset_i] : '0;
      dirty_bit_q  <= miss_dirty;
      victim_tag_q <= (accept && !hit_any) ? victim_line.tag : '0;
      dirty_blk_q  <= miss_dirty ? data_q[victim_way][index_i] : '0;
      done_q       <= refill_en || inval_last;
      if (accept && !hit_any) victim_way_q <= victim_way;
    end
  end

  assign resp_valid_o      = resp_valid_q;
  assign hit_o             = hit_q;
  assign data_out_o        = data_out_q;
  assign dirty_bit_o       = dirty_bit_q;
  assign victim_tag_o      = victim_tag_q;
  assign dirty_block_out_o = dirty_blk_q;
  assign done_cache_o      = done_q;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup counters; invalidate-all starts a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (inval_start) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit_any && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit_any && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_cache_memory_assoc.sv
// Scoreboard bench for cache_memory_assoc: directed scenarios plus randomized lookups,
// checked against a recency-list reference model.
module tb_cache_memory_assoc;
  import cache_memory_assoc_pkg::*;

  localparam int NS  = 64;
  localparam int NW  = 2;
  localparam int WPB = 4;
  localparam int WS  = 32;
  localparam int AW  = 32;
  localparam int IW  = 6;
  localparam int OW  = 2;
  localparam int TW  = AW - IW - OW - 2;
  localparam int BS  = WPB * WS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_type = 1'b0;
  logic [TW-1:0] tag = '0;
  logic [IW-1:0] index = '0;
  logic [OW-1:0] blk_offset = '0;
  logic [WS-1:0] data_in = '0;
  logic          refill_valid = 1'b0, inval_all = 1'b0;
  logic [BS-1:0] data_in_mem = '0;
  logic          resp_valid, hit, dirty_bit, done_cache;
  logic [WS-1:0] data_out;
  logic [TW-1:0] victim_tag;
  logic [BS-1:0] dirty_block_out;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]   hit_count, miss_count;
`endif

  cache_memory_assoc dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_type_i       (req_type),
    .tag_i            (tag),
    .index_i          (index),
    .blk_offset_i     (blk_offset),
    .data_in_i        (data_in),
    .refill_valid_i   (refill_valid),
    .data_in_mem_i    (data_in_mem),
    .inval_all_i      (inval_all),
    .resp_valid_o     (resp_valid),
    .hit_o            (hit),
    .data_out_o       (data_out),
    .dirty_bit_o      (dirty_bit),
    .victim_tag_o     (victim_tag),
    .dirty_block_out_o(dirty_block_out),
    .done_cache_o     (done_cache)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            cyc;
    bit            hit;
    logic [WS-1:0] data;
    bit            dirty;
    bit            chk_vtag;
    logic [TW-1:0] vtag;
    logic [BS-1:0] blk;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  bit            m_valid [NW][NS];
  bit            m_dirty [NW][NS];
  logic [TW-1:0] m_tag   [NW][NS];
  logic [WS-1:0] m_data  [NW][NS][WPB];
  int            m_rec   [NS][NW];  // ways ordered most- to least-recently used
  int            m_victim;

  function automatic void model_clear_lines();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        m_rec[s][w]   = w;
      end
    end
  endfunction

  function automatic void model_reset();
    model_clear_lines();
    m_victim = 0;
  endfunction

  function automatic void touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (m_rec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
    m_rec[s][0] = w;
  endfunction

  function automatic int pick_victim(input int s);
    for (int w = 0; w < NW; w++) if (!m_valid[w][s]) return w;
    return m_rec[s][NW-1];
  endfunction

  function automatic logic [BS-1:0] get_blk(input int w, input int s);
    logic [BS-1:0] b;
    for (int k = 0; k < WPB; k++) b[k*WS +: WS] = m_data[w][s][k];
    return b;
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  bit   mon_done_exp;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        chk("resp_valid", resp_valid, 1'b1);
        if (resp_valid) begin
          chk("hit", hit, mon_e.hit);
          chk("data_out", data_out, mon_e.data);
          chk("dirty_bit", dirty_bit, mon_e.dirty);
          if (mon_e.chk_vtag) chk("victim_tag", victim_tag, mon_e.vtag);
          chk("dirty_block_out", dirty_block_out, mon_e.blk);
        end
      end else begin
        chk("resp_valid_idle", resp_valid, 1'b0);
      end
      mon_done_exp = (done_q.size() > 0 && done_q[0] == cyc);
      if (mon_done_exp) void'(done_q.pop_front());
      chk("done_cache", done_cache, mon_done_exp);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input bit wr, input logic [TW-1:0] tg, input int s, input int off,
                        input logic [WS-1:0] d, output bit was_hit);
    exp_t e;
    int   hw = -1;
    int   v;
    req_valid  = 1'b1;
    req_type   = wr;
    tag        = tg;
    index      = IW'(s);
    blk_offset = OW'(off);
    data_in    = d;
    #1;
    chk("req_ready_lookup", req_ready, 1'b1);
    for (int w = 0; w < NW; w++) if (m_valid[w][s] && m_tag[w][s] == tg) hw = w;
    e.cyc = cyc + 1; e.hit = (hw >= 0); e.data = '0; e.dirty = 1'b0;
    e.chk_vtag = 1'b1; e.vtag = '0; e.blk = '0;
    if (hw >= 0) begin
      if (wr) begin
        m_data[hw][s][off] = d;
        m_dirty[hw][s]     = 1'b1;
      end else begin
        e.data = m_data[hw][s][off];
      end
      touch(s, hw);
    end else begin
      v = pick_victim(s);
      if (m_valid[v][s]) begin
        e.vtag = m_tag[v][s];
        if (m_dirty[v][s]) begin
          e.dirty = 1'b1;
          e.blk   = get_blk(v, s);
        end
      end else begin
        e.chk_vtag = 1'b0;
      end
      m_victim = v;
    end
    exp_q.push_back(e);
    was_hit = (hw >= 0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic refill(input logic [TW-1:0] tg, input int s, input logic [BS-1:0] blk,
                        input bit also_req);
    refill_valid = 1'b1;
    req_valid    = also_req;
    tag          = tg;
    index        = IW'(s);
    data_in_mem  = blk;
    #1;
    chk("req_ready_refill", req_ready, 1'b0);
    for (int k = 0; k < WPB; k++) m_data[m_victim][s][k] = blk[k*WS +: WS];
    m_tag[m_victim][s]   = tg;
    m_valid[m_victim][s] = 1'b1;
    m_dirty[m_victim][s] = 1'b0;
    touch(s, m_victim);
    done_q.push_back(cyc + 1);
    tick();
    refill_valid = 1'b0;
    req_valid    = 1'b0;
  endtask

  task automatic do_inval(input bit with_req, input bit with_refill);
    inval_all    = 1'b1;
    req_valid    = with_req;
    refill_valid = with_refill;
    #1;
    chk("req_ready_inval_issue", req_ready, !with_refill);
    done_q.push_back(cyc + 1 + NS);
    model_clear_lines();
    tick();
    inval_all    = 1'b0;
    refill_valid = 1'b0;
    req_valid    = 1'b1;  // must be ignored while the walk runs
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      chk("req_ready_during_inval", req_ready, 1'b0);
      if (i == NS - 1) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("req_ready_after_inval", req_ready, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_dirty_bit", dirty_bit, 1'b0);
    chk("rst_victim_tag", victim_tag, '0);
    chk("rst_dirty_block_out", dirty_block_out, '0);
    chk("rst_done_cache", done_cache, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
  endtask

  localparam logic [TW-1:0] TAG_A = 22'h0A1;
  localparam logic [TW-1:0] TAG_B = 22'h0B2;
  localparam logic [TW-1:0] TAG_C = 22'h0C3;

  bit            h;
  logic [BS-1:0] rblk;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    tick();

    // Basic miss, refill into way 0, read hit, write hit then read back.
    lookup(1'b0, 22'h12, 3, 0, '0, h);
    refill(22'h12, 3, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444, 1'b1);
    lookup(1'b0, 22'h12, 3, 1, '0, h);
    lookup(1'b1, 22'h12, 3, 2, 32'hDEADBEEF, h);
    lookup(1'b0, 22'h12, 3, 2, '0, h);

    // LRU victim choice and dirty eviction in set 5.
    lookup(1'b0, TAG_A, 5, 0, '0, h);
    refill(TAG_A, 5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    lookup(1'b0, TAG_B, 5, 0, '0, h);
    refill(TAG_B, 5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    lookup(1'b0, TAG_A, 5, 3, '0, h);
    lookup(1'b0, TAG_C, 5, 0, '0, h);
    lookup(1'b1, TAG_B, 5, 1, 32'h1234_5678, h);
    lookup(1'b0, TAG_A, 5, 0, '0, h);
    lookup(1'b0, TAG_C, 5, 0, '0, h);
    refill(TAG_C, 5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    lookup(1'b0, TAG_B, 5, 1, '0, h);
    lookup(1'b0, TAG_C, 5, 2, '0, h);

    // Invalidate-all wins over refill and lookup in the same cycle.
    tag = TAG_A; index = IW'(5);
    do_inval(1'b1, 1'b1);
    lookup(1'b0, TAG_A, 5, 0, '0, h);
    lookup(1'b0, 22'h12, 3, 0, '0, h);
    lookup(1'b0, TAG_C, 5, 0, '0, h);

    // Reset in the middle of the invalidate walk: no completion pulse, all lines invalid.
    refill(TAG_C, 5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    inval_all = 1'b1;
    tick();
    inval_all = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    repeat (NS + 5) tick();
    lookup(1'b0, TAG_C, 5, 0, '0, h);
    lookup(1'b0, 22'h12, 3, 0, '0, h);

    // Randomized lookups over a small tag/set pool so hits, evictions and dirty victims mix.
    for (int n = 0; n < 500; n++) begin
      int r;
      int s;
      logic [TW-1:0] tg;
      r  = $urandom_range(99);
      s  = 8 + $urandom_range(2);
      tg = TW'(22'h100 + $urandom_range(3));
      if (r < 1) begin
        do_inval($urandom_range(1) == 1, 1'b0);
      end else if (r < 8) begin
        tick();
      end else begin
        lookup($urandom_range(1) == 1, tg, s, $urandom_range(WPB - 1), $urandom, h);
        if (!h && $urandom_range(3) != 0) begin
          rblk = {$urandom, $urandom, $urandom, $urandom};
          refill(tg, s, rblk, $urandom_range(1) == 1);
        end
      end
    end

    repeat (5) tick();
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
